c1541_gcr_track_ctrl: RTL and testbench
=======================================

Name: c1541_gcr_track_ctrl

Overview:
Sequences track transfers between the SD block interface and the 8 KB direct-GCR track buffer of the 1541 drive. Tracks head position, debounces stepper moves, writes back a modified track before loading a new one, and holds the GCR engine's busy input while the buffer is being exchanged. Sits between the drive's stepper/motor logic, the GCR bit engine and the SD block port.

Parameters:
SETTLE_CYC, 16'd20000, clk cycles half_track must stay stable before a load starts
BLKS_PER_TRK, 5, log2 of 512-byte blocks per track slot (32 blocks = 16 KB slot, 8 KB used)
MAX_HTRK, 7'd83, highest legal half-track index

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
img_mounted  in  1  one-cycle pulse: new image mounted
img_readonly  in  1  image is write-protected
lba_base  in  32  LBA of half-track 0 in the image
half_track  in  7  current head position from stepper
mtr  in  1  spindle motor on
gcr_we  in  1  write strobe from GCR engine (one per bit written)
busy  out  1  to GCR engine: buffer not valid/being exchanged
sd_lba  out  32  block address of current request
sd_blk_cnt  out  6  blocks minus one for current request
sd_rd  out  1  read request
sd_wr  out  1  write request
sd_ack  in  1  SD transfer in progress
cur_track  out  7  half-track held in buffer
dirty  out  1  buffer modified since load

Behaviour:
- Reset values: busy=1, sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=15, cur_track=0, dirty=0, valid=0, state=IDLE, settle counter=0.
- Requested track = min(half_track, MAX_HTRK); sampled each cycle.
- sd_lba = lba_base + (track << BLKS_PER_TRK), 32-bit wrap-around. sd_blk_cnt fixed at 15 (16 blocks = 8 KB).
- States:
  - IDLE: if !valid or requested track != cur_track -> SETTLE (counter cleared). Else busy=0.
  - SETTLE: busy=1; counter increments; requested track change clears counter. Counter == SETTLE_CYC-1 -> FLUSH if dirty && !img_readonly, else LOAD.
  - FLUSH: sd_lba from cur_track; sd_wr=1 until sd_ack seen high, then dropped; on sd_ack falling edge dirty<=0, -> LOAD.
  - LOAD: latch requested track into cur_track on entry; sd_rd=1 until sd_ack high; on sd_ack falling edge valid<=1 -> IDLE.
- sd_rd and sd_wr never both high; each deasserts the cycle after sd_ack is first sampled high.
- busy=1 in every state except IDLE with valid=1.
- dirty set by gcr_we when busy=0 && !img_readonly; gcr_we while busy=1 ignored.
- Head move during FLUSH/LOAD: transfer completes (SD cannot abort); IDLE then sees mismatch and re-enters SETTLE.
- img_mounted pulse: valid<=0, dirty<=0 (old image discarded, no flush). In FLUSH/LOAD: transfer completes, then the load result is discarded (valid stays 0) and the track is reloaded from IDLE.
- mtr=0 does not stop a transfer in progress; loads are not gated by mtr.
- Asynchronous reset mid-transfer: outputs go to reset values immediately; no resume.

Optional Feature:
GCR_FLUSH_ON_MTR_OFF_EN:
- Defined: falling edge of mtr in IDLE with dirty && !img_readonly -> FLUSH of cur_track, then back to IDLE. No reload; valid stays 1.
- Undefined: dirty data is written back only on track change.

Decomposition:
- Package c1541_gcr_pkg: state enum (IDLE, SETTLE, FLUSH, LOAD), TRK_BLKS=16, MAX_HTRK default, LBA width constant.
- Sub-module c1541_sd_req: one-request handshake (req hold until ack, done on ack fall), instantiated once and shared by FLUSH and LOAD.

Test Plan:
- Reset release, half_track=36, lba_base=0x1000, SETTLE_CYC=8 -> after 8 cycles sd_rd=1, sd_lba=0x1000+36*32=0x1480; ack high 3 cycles then low -> busy=0, cur_track=36.
- gcr_we pulse at track 36, then half_track=38 -> SETTLE, sd_wr with sd_lba=0x1480, then sd_rd with sd_lba=0x14C0; dirty=0 after flush.
- Same as above but img_readonly=1 -> no sd_wr; dirty never set.
- half_track toggles 36/37 every 5 cycles (SETTLE_CYC=8) -> no sd_rd; steady 37 -> single load at 0x14A0.
- half_track=90 -> cur_track=83, sd_lba=lba_base+83*32.
- img_mounted mid-LOAD -> load completes, busy stays 1, second sd_rd issued; with GCR_FLUSH_ON_MTR_OFF_EN, dirty + mtr falling -> one sd_wr, busy returns 0.

Source files
------------

// File: rtl/c1541_gcr_pkg.sv
// Shared types and constants for the 1541 GCR track buffer controller.
package c1541_gcr_pkg;

   localparam int unsigned LbaW         = 32;
   localparam int unsigned TRK_BLKS     = 16;
   localparam logic [6:0]  MAX_HTRK_DEF = 7'd83;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StFlush,
      StLoad
   } state_e;

endpackage

// File: rtl/c1541_gcr_track_ctrl_if.sv
// SD block port: one outstanding read or write request, acknowledged by sd_ack.
interface c1541_gcr_track_ctrl_if;
   import c1541_gcr_pkg::*;

   logic [LbaW-1:0] sd_lba;
   logic [5:0]      sd_blk_cnt;
   logic            sd_rd;
   logic            sd_wr;
   logic            sd_ack;

   modport master (output sd_lba, output sd_blk_cnt, output sd_rd, output sd_wr, input sd_ack);
   modport slave  (input sd_lba, input sd_blk_cnt, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/c1541_sd_req.sv
// Single-request SD handshake: req held from start until ack is seen, done on ack falling.
module c1541_sd_req (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic ack,
   output logic req,
   output logic done
);

   logic req_q;
   logic active_q;
   logic ack_q;

   assign req  = req_q;
   assign done = active_q && ack_q && !ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q    <= 1'b0;
         active_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         ack_q <= ack;
         if (start) begin
            req_q    <= 1'b1;
            active_q <= 1'b1;
         end else begin
            if (ack)  req_q    <= 1'b0;
            if (done) active_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/c1541_gcr_track_ctrl.sv
// Track buffer sequencer: settle, write back dirty track, load requested track.
// Optional GCR_FLUSH_ON_MTR_OFF_EN: write back dirty track when the motor turns off.
module c1541_gcr_track_ctrl
   import c1541_gcr_pkg::*;
#(
   parameter logic [15:0] SETTLE_CYC   = 16'd20000,
   parameter int unsigned BLKS_PER_TRK = 5,
   parameter logic [6:0]  MAX_HTRK     = MAX_HTRK_DEF
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          img_mounted,
   input  logic                          img_readonly,
   input  logic [LbaW-1:0]               lba_base,
   input  logic [6:0]                    half_track,
   input  logic                          mtr,
   input  logic                          gcr_we,
   output logic                          busy,
   c1541_gcr_track_ctrl_if.master        sd,
   output logic [6:0]                    cur_track,
   output logic                          dirty
);

   state_e          state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [6:0]      cur_q, cur_d;
   logic [6:0]      last_req_q;
   logic [LbaW-1:0] lba_q, lba_d;
   logic            dirty_q, dirty_d;
   logic            valid_q, valid_d;
   logic            discard_q, discard_d;
   logic            flush_only_q, flush_only_d;
   logic [6:0]      req_trk;
   logic            start, req, done, mtr_fall;

   function automatic logic [LbaW-1:0] trk_lba(input logic [LbaW-1:0] base, input logic [6:0] t);
      return base + (LbaW'(t) << BLKS_PER_TRK);
   endfunction

   assign req_trk = (half_track > MAX_HTRK) ? MAX_HTRK : half_track;
   assign busy    = !((state_q == StIdle) && valid_q);

`ifdef GCR_FLUSH_ON_MTR_OFF_EN
   logic mtr_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mtr_q <= 1'b0;
      else          mtr_q <= mtr;
   end
   assign mtr_fall = mtr_q && !mtr;
`else
   logic unused_mtr;
   assign unused_mtr = mtr;
   assign mtr_fall   = 1'b0;
`endif

   c1541_sd_req u_sd_req (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .ack     (sd.sd_ack),
      .req     (req),
      .done    (done)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cur_d        = cur_q;
      lba_d        = lba_q;
      dirty_d      = dirty_q;
      valid_d      = valid_q;
      discard_d    = discard_q;
      flush_only_d = flush_only_q;
      start        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!valid_q || (req_trk != cur_q)) begin
               state_d = StSettle;
               cnt_d   = 16'd0;
            end else if (mtr_fall && dirty_q && !img_readonly) begin
               state_d      = StFlush;
               flush_only_d = 1'b1;
               start        = 1'b1;
               lba_d        = trk_lba(lba_base, cur_q);
            end
         end
         StSettle: begin
            if (req_trk != last_req_q) begin
               cnt_d = 16'd0;
            end else if (cnt_q == SETTLE_CYC - 16'd1) begin
               start = 1'b1;
               if (dirty_q && !img_readonly) begin
                  state_d      = StFlush;
                  flush_only_d = 1'b0;
                  lba_d        = trk_lba(lba_base, cur_q);
               end else begin
                  state_d = StLoad;
                  cur_d   = req_trk;
                  lba_d   = trk_lba(lba_base, req_trk);
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StFlush: begin
            if (done) begin
               dirty_d = 1'b0;
               if (flush_only_q) begin
                  state_d   = StIdle;
                  discard_d = 1'b0;
               end else begin
                  state_d = StLoad;
                  start   = 1'b1;
                  cur_d   = req_trk;
                  lba_d   = trk_lba(lba_base, req_trk);
               end
            end
         end
         StLoad: begin
            if (done) begin
               state_d   = StIdle;
               valid_d   = !discard_q;
               discard_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (gcr_we && !busy && !img_readonly) dirty_d = 1'b1;

      // A mount drops the old image; a transfer in flight still has to finish first.
      if (img_mounted) begin
         valid_d = 1'b0;
         dirty_d = 1'b0;
         if ((state_d == StFlush) || (state_d == StLoad)) discard_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_q        <= 16'd0;
         cur_q        <= 7'd0;
         last_req_q   <= 7'd0;
         lba_q        <= '0;
         dirty_q      <= 1'b0;
         valid_q      <= 1'b0;
         discard_q    <= 1'b0;
         flush_only_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_q        <= cur_d;
         last_req_q   <= req_trk;
         lba_q        <= lba_d;
         dirty_q      <= dirty_d;
         valid_q      <= valid_d;
         discard_q    <= discard_d;
         flush_only_q <= flush_only_d;
      end
   end

   assign sd.sd_lba     = lba_q;
   assign sd.sd_blk_cnt = 6'(TRK_BLKS - 1);
   assign sd.sd_rd      = req && (state_q == StLoad);
   assign sd.sd_wr      = req && (state_q == StFlush);
   assign cur_track     = cur_q;
   assign dirty         = dirty_q;

endmodule

// File: tb/tb_c1541_gcr_track_ctrl.sv
// Self-checking bench: vector table of head moves plus settle, mount and motor-off sequences.
module tb_c1541_gcr_track_ctrl;

   localparam logic [31:0] Base = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        img_mounted = 1'b0;
   logic        img_readonly = 1'b0;
   logic [31:0] lba_base = Base;
   logic [6:0]  half_track = 7'd36;
   logic        mtr = 1'b1;
   logic        gcr_we = 1'b0;
   logic        busy;
   logic [6:0]  cur_track;
   logic        dirty;

   int checks = 0;
   int errors = 0;
   int n_req  = 0;

   typedef struct packed {
      logic        wr;
      logic [31:0] lba;
   } req_t;
   req_t sb[$];

   typedef struct {
      logic [6:0] ht;
      logic       we;
      logic       ro;
      logic [6:0] exp_trk;
   } vec_t;
   vec_t vecs[7];

   c1541_gcr_track_ctrl_if sif ();

   c1541_gcr_track_ctrl #(
      .SETTLE_CYC   (16'd8),
      .BLKS_PER_TRK (5),
      .MAX_HTRK     (7'd83)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .img_mounted  (img_mounted),
      .img_readonly (img_readonly),
      .lba_base     (lba_base),
      .half_track   (half_track),
      .mtr          (mtr),
      .gcr_we       (gcr_we),
      .busy         (busy),
      .sd           (sif.master),
      .cur_track    (cur_track),
      .dirty        (dirty)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_lba(input int trk);
      return Base + 32'(trk * 32);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   task automatic pulse_we();
      @(negedge clk) gcr_we = 1'b1;
      @(negedge clk) gcr_we = 1'b0;
   endtask

   // SD model: pops the expected request, acks for three cycles, then releases.
   initial begin
      req_t e;
      sif.sd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (sif.sd_rd || sif.sd_wr) begin
            n_req++;
            chk("rd_wr_exclusive", 32'(sif.sd_rd && sif.sd_wr), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got wr=%0b lba=0x%08h, required no request",
                        sif.sd_wr, sif.sd_lba);
            end else begin
               e = sb.pop_front();
               chk("req_is_wr", 32'(sif.sd_wr), 32'(e.wr));
               chk("req_lba", sif.sd_lba, e.lba);
               chk("req_blk_cnt", 32'(sif.sd_blk_cnt), 32'd15);
            end
            sif.sd_ack = 1'b1;
            repeat (3) @(negedge clk);
            chk("req_dropped_on_ack", 32'(sif.sd_rd || sif.sd_wr), 32'd0);
            sif.sd_ack = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      int prev;
      int nr;
      logic dexp;

      vecs[0] = '{ht: 7'd36,  we: 1'b0, ro: 1'b0, exp_trk: 7'd36};
      vecs[1] = '{ht: 7'd38,  we: 1'b1, ro: 1'b0, exp_trk: 7'd38};
      vecs[2] = '{ht: 7'd90,  we: 1'b0, ro: 1'b0, exp_trk: 7'd83};
      vecs[3] = '{ht: 7'd0,   we: 1'b1, ro: 1'b1, exp_trk: 7'd0};
      vecs[4] = '{ht: 7'd127, we: 1'b1, ro: 1'b0, exp_trk: 7'd83};
      vecs[5] = '{ht: 7'd83,  we: 1'b0, ro: 1'b0, exp_trk: 7'd83};
      vecs[6] = '{ht: 7'd36,  we: 1'b0, ro: 1'b0, exp_trk: 7'd36};

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_sd_rd", 32'(sif.sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(sif.sd_wr), 32'd0);
      chk("rst_sd_lba", sif.sd_lba, 32'd0);
      chk("rst_blk_cnt", 32'(sif.sd_blk_cnt), 32'd15);
      chk("rst_cur_track", 32'(cur_track), 32'd0);
      chk("rst_dirty", 32'(dirty), 32'd0);

      prev = -1;
      for (int i = 0; i < 7; i++) begin
         img_readonly = vecs[i].ro;
         dexp = 1'b0;
         if (vecs[i].we && prev >= 0) begin
            pulse_we();
            dexp = !vecs[i].ro;
            chk("dirty_after_we", 32'(dirty), 32'(dexp));
         end
         if (int'(vecs[i].exp_trk) != prev) begin
            if (dexp) sb.push_back('{wr: 1'b1, lba: exp_lba(prev)});
            sb.push_back('{wr: 1'b0, lba: exp_lba(int'(vecs[i].exp_trk))});
         end
         @(negedge clk) half_track = vecs[i].ht;
         if (i == 0) reset_n = 1'b1;
         repeat (2) @(negedge clk);
         wait_idle("vec_idle_timeout");
         chk("vec_cur_track", 32'(cur_track), 32'(vecs[i].exp_trk));
         chk("vec_dirty", 32'(dirty), 32'd0);
         chk("vec_sb_empty", 32'(sb.size()), 32'd0);
         prev = int'(vecs[i].exp_trk);
      end

      // Head jitters faster than the settle window: no transfer until it rests.
      nr = n_req;
      for (int k = 0; k < 8; k++) begin
         half_track = (k % 2 == 0) ? 7'd37 : 7'd36;
         repeat (5) @(negedge clk);
      end
      chk("toggle_no_req", 32'(n_req - nr), 32'd0);
      sb.push_back('{wr: 1'b0, lba: 32'h0000_14A0});
      half_track = 7'd37;
      repeat (2) @(negedge clk);
      wait_idle("toggle_idle_timeout");
      chk("toggle_cur_track", 32'(cur_track), 32'd37);
      chk("toggle_sb_empty", 32'(sb.size()), 32'd0);

      // Mount during a load: load completes, result dropped, track reloaded.
      sb.push_back('{wr: 1'b0, lba: exp_lba(40)});
      sb.push_back('{wr: 1'b0, lba: exp_lba(40)});
      half_track = 7'd40;
      begin
         int n = 0;
         while (!sif.sd_ack && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk("mount_ack_timeout", 32'(sif.sd_ack), 32'd1);
      end
      img_mounted = 1'b1;
      @(negedge clk) img_mounted = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mount_busy_held", 32'(busy), 32'd1);
      end
      wait_idle("mount_idle_timeout");
      chk("mount_cur_track", 32'(cur_track), 32'd40);
      chk("mount_sb_empty", 32'(sb.size()), 32'd0);

      pulse_we();
      chk("mtr_dirty_set", 32'(dirty), 32'd1);
      nr = n_req;
`ifdef GCR_FLUSH_ON_MTR_OFF_EN
      sb.push_back('{wr: 1'b1, lba: exp_lba(40)});
      mtr = 1'b0;
      repeat (2) @(negedge clk);
      wait_idle("mtr_idle_timeout");
      chk("mtr_one_write", 32'(n_req - nr), 32'd1);
      chk("mtr_dirty_clear", 32'(dirty), 32'd0);
      chk("mtr_cur_track", 32'(cur_track), 32'd40);
      chk("mtr_sb_empty", 32'(sb.size()), 32'd0);
`else
      mtr = 1'b0;
      repeat (20) @(negedge clk);
      chk("mtr_no_req", 32'(n_req - nr), 32'd0);
      chk("mtr_dirty_kept", 32'(dirty), 32'd1);
      chk("mtr_busy", 32'(busy), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
